// File: rtl/ioports_pkg.sv
// Shared definitions for the I/O port byte protocol: opcodes, hardware ID,
// host sequencer states and the command-byte packing helper.
package ioports_pkg;

  localparam logic [2:0]  CMD_RESET  = 3'b001;
  localparam logic [2:0]  CMD_WRITE  = 3'b010;
  localparam logic [2:0]  CMD_READ   = 3'b011;
  localparam logic [3:0]  HWID_ADDR  = 4'd15;
  localparam logic [31:0] ATLYS_HWID = 32'h2019_2020;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_RD_REQ,
    ST_RD_REL,
    ST_DONE
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic [2:0] op, input logic [3:0] addr);
    return {1'b0, op, addr};
  endfunction

endpackage

// File: rtl/ioports_host.sv
// Host-side initiator: serialises word commands into load/datain bytes and
// collects four read bytes through the ready/enout handshake.
module ioports_host
  import ioports_pkg::*;
#(
  parameter int GAP     = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        load,
  output logic [7:0]  datain,
  output logic        ready,
  input  logic        enout,
  input  logic [7:0]  dataout
);

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        load_q, load_d;
  logic [7:0]  datain_q, datain_d;
  logic        ready_q, ready_d;

  logic [2:0]  op_q, op_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] wait_q, wait_d;
  logic [2:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  n_bytes;

  function automatic logic [7:0] tx_byte(input logic [2:0] idx, input logic [2:0] op,
                                         input logic [3:0] addr, input logic [31:0] wd);
    case (idx)
      3'd1:    return wd[31:24];
      3'd2:    return wd[23:16];
      3'd3:    return wd[15:8];
      3'd4:    return wd[7:0];
      default: return cmd_byte(op, addr);
    endcase
  endfunction

  assign n_bytes = (op_q == CMD_WRITE) ? 3'd5 : 3'd1;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    byte_idx_d  = byte_idx_q;
    gap_cnt_d   = gap_cnt_q;
    wait_d      = wait_q;
    rd_cnt_d    = rd_cnt_q;
    shift_d     = shift_q;
    datain_d    = datain_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = {1'b0, cmd_op};
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          byte_idx_d = '0;
          if (cmd_op == 2'd0) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = ST_SEND;
            datain_d = cmd_byte({1'b0, cmd_op}, cmd_addr);
          end
        end
      end
      ST_SEND: begin
        byte_idx_d = byte_idx_q + 3'd1;
        gap_cnt_d  = '0;
        state_d    = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt_q == 16'(GAP - 1)) begin
          if (byte_idx_q < n_bytes) begin
            state_d  = ST_SEND;
            datain_d = tx_byte(byte_idx_q, op_q, addr_q, wdata_q);
          end else if (op_q == CMD_READ) begin
            state_d  = ST_RD_REQ;
            wait_d   = '0;
            rd_cnt_d = '0;
          end else begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      ST_RD_REQ: begin
        if (enout) begin
          shift_d  = {shift_q[23:0], dataout};
          rd_cnt_d = rd_cnt_q + 3'd1;
          wait_d   = '0;
          state_d  = ST_RD_REL;
        end else if (wait_q == 16'(TIMEOUT - 1)) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_RD_REL: begin
        if (!enout) begin
          wait_d = '0;
          if (rd_cnt_q == 3'd4) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = shift_q;
          end else begin
            state_d = ST_RD_REQ;
          end
        end else if (wait_q == 16'(TIMEOUT - 1)) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Outputs are registered, so they are decoded from the state being entered.
    cmd_ready_d = (state_d == ST_IDLE);
    load_d      = (state_d == ST_SEND);
    ready_d     = (state_d == ST_RD_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      load_q      <= 1'b0;
      datain_q    <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      load_q      <= load_d;
      datain_q    <= datain_d;
      ready_q     <= ready_d;
    end
  end

  // Working registers are always (re)initialised on the transition that uses them.
  always_ff @(posedge clk) begin
    op_q       <= op_d;
    addr_q     <= addr_d;
    wdata_q    <= wdata_d;
    byte_idx_q <= byte_idx_d;
    gap_cnt_q  <= gap_cnt_d;
    wait_q     <= wait_d;
    rd_cnt_q   <= rd_cnt_d;
    shift_q    <= shift_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign load      = load_q;
  assign datain    = datain_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_ioports_host.sv
// Bench for ioports_host: a behavioural I/O port target plus directed and
// randomized command sequences checked against an arithmetic reference.
module tb_ioports_host;

  localparam int GAP     = 1;
  localparam int TIMEOUT = 255;
  localparam int BOUND   = 400;

  logic        clk, reset, cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err, load, ready, enout;
  logic [31:0] rsp_rdata;
  logic [7:0]  datain, dataout;

  int checks = 0;
  int errors = 0;

  ioports_host #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .load(load), .datain(datain), .ready(ready), .enout(enout), .dataout(dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural target: decodes command bytes, stores writes, serves reads.
  logic [31:0] tgt_out [16];
  logic [31:0] tgt_in  [16];
  logic [31:0] ref_out [16];
  logic [31:0] wr_acc, rd_word;
  logic [3:0]  wr_addr;
  logic [2:0]  wr_left, rd_left;
  logic        outf, mute;
  int          outf_pulses = 0;

  always @(posedge clk) begin
    outf <= 1'b0;
    if (reset) begin
      wr_left <= 3'd0;
      rd_left <= 3'd0;
      enout   <= 1'b0;
      dataout <= 8'd0;
      for (int i = 0; i < 16; i++) tgt_out[i] <= 32'd0;
    end else begin
      if (load) begin
        if (wr_left != 3'd0) begin
          wr_acc  <= {wr_acc[23:0], datain};
          wr_left <= wr_left - 3'd1;
          if (wr_left == 3'd1) begin
            if (wr_addr == 4'd15) begin
              outf        <= datain[0];
              outf_pulses <= outf_pulses + 1;
            end else begin
              tgt_out[wr_addr] <= {wr_acc[23:0], datain};
            end
          end
        end else begin
          case (datain[6:4])
            3'd1: for (int i = 0; i < 16; i++) tgt_out[i] <= 32'd0;
            3'd2: begin wr_left <= 3'd4; wr_addr <= datain[3:0]; end
            3'd3: begin
              rd_left <= 3'd4;
              rd_word <= (datain[3:0] == 4'd15) ? 32'h2019_2020 : tgt_in[datain[3:0]];
            end
            default: ;
          endcase
        end
      end
      if (!enout && ready && rd_left != 3'd0 && !mute) begin
        enout   <= 1'b1;
        dataout <= rd_word[31:24];
        rd_word <= rd_word << 8;
        rd_left <= rd_left - 3'd1;
      end else if (enout && !ready) begin
        enout <= 1'b0;
      end
    end
  end

  // Per-command observation, filled by do_cmd.
  int          ld_cyc[$];
  logic [7:0]  ld_byte[$];
  int          rdy_cyc[$];
  int          rsp_cyc, acc_wait;
  logic [31:0] rsp_data;
  logic        rsp_e, rsp_rdy_low;
  bit          got_rsp, accepted;

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr,
                        input logic [31:0] wd, input int abort_rel);
    ld_cyc.delete(); ld_byte.delete(); rdy_cyc.delete();
    got_rsp = 0; accepted = 0; rsp_cyc = -1; acc_wait = 0;
    rsp_data = 32'hx; rsp_e = 1'bx; rsp_rdy_low = 1'bx;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    for (int k = 0; k < 50 && !accepted; k++) begin
      if (cmd_ready) accepted = 1;
      else begin acc_wait++; @(negedge clk); end
    end
    if (!accepted) begin
      cmd_valid = 1'b0;
      return;
    end
    for (int rel = 1; rel <= BOUND && !got_rsp; rel++) begin
      @(negedge clk);
      if (rel == 1) cmd_valid = 1'b0;
      if (load) begin ld_cyc.push_back(rel); ld_byte.push_back(datain); end
      if (ready) rdy_cyc.push_back(rel);
      if (rsp_valid) begin
        got_rsp = 1; rsp_cyc = rel; rsp_data = rsp_rdata; rsp_e = rsp_err; rsp_rdy_low = !ready;
      end
      if (rel == abort_rel) begin reset = 1'b1; break; end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 4'd0; cmd_wdata = 32'd0; mute = 1'b0;
    for (int i = 0; i < 16; i++) begin tgt_in[i] = 32'd0; ref_out[i] = 32'd0; end
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, load, ready} !== 5'b0 || rsp_rdata !== 32'd0 || datain !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got cr=%b rv=%b re=%b ld=%b rdy=%b rd=%h di=%h required all 0",
               cmd_ready, rsp_valid, rsp_err, load, ready, rsp_rdata, datain);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    bit ok;
    logic [7:0] exp_b [5] = '{8'h23, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_cmd(2'd2, 4'd3, 32'hDEADBEEF, 0);
    ref_out[3] = 32'hDEADBEEF;
    ok = (ld_byte.size() == 5);
    for (int k = 0; k < 5 && ok; k++)
      if (ld_byte[k] !== exp_b[k] || ld_cyc[k] !== 1 + k * (1 + GAP)) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL write_bytes got %0d bytes first %h required 23 DE AD BE EF at cycles 1,3,5,7,9",
                         ld_byte.size(), (ld_byte.size() > 0) ? ld_byte[0] : 8'hxx);
    end
    checks++;
    if (!got_rsp || rsp_cyc !== 11 || rsp_e !== 1'b0 || rsp_data !== 32'd0) begin
      errors++; $display("FAIL write_rsp got cyc=%0d err=%b rdata=%h required cyc=11 err=0 rdata=0", rsp_cyc, rsp_e, rsp_data);
    end
    checks++;
    if (tgt_out[3] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_target got out3=%h required deadbeef", tgt_out[3]);
    end
  endtask

  task automatic test_read_hwid();
    bit ok;
    do_cmd(2'd3, 4'd15, 32'd0, 0);
    checks++;
    if (ld_byte.size() != 1 || ld_byte[0] !== 8'h3F || ld_cyc[0] !== 1) begin
      errors++; $display("FAIL read_cmd_byte got %0d loads first %h required one load of 3f in cycle 1",
                         ld_byte.size(), (ld_byte.size() > 0) ? ld_byte[0] : 8'hxx);
    end
    ok = (rdy_cyc.size() == 8);
    for (int j = 0; j < 8 && ok; j++)
      if (rdy_cyc[j] !== 2 + GAP + 4 * (j / 2) + (j % 2)) ok = 0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL read_ready_cycles got %0d ready cycles required 3-4,7-8,11-12,15-16", rdy_cyc.size());
    end
    checks++;
    if (!got_rsp || rsp_cyc !== 19 || rsp_data !== 32'h2019_2020 || rsp_e !== 1'b0) begin
      errors++; $display("FAIL read_hwid got cyc=%0d rdata=%h err=%b required cyc=19 rdata=20192020 err=0", rsp_cyc, rsp_data, rsp_e);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = outf_pulses;
    tgt_in[0] = 32'hA5A5_0001;
    do_cmd(2'd2, 4'd15, 32'h1, 0);
    checks++;
    if (!got_rsp || rsp_cyc !== 11) begin
      errors++; $display("FAIL b2b_write_rsp got cyc=%0d required 11", rsp_cyc);
    end
    do_cmd(2'd3, 4'd0, 32'd0, 0);
    checks++;
    if (acc_wait !== 1) begin
      errors++; $display("FAIL b2b_cmd_ready got wait=%0d required 1 cycle after rsp_valid", acc_wait);
    end
    checks++;
    if (outf_pulses !== p0 + 1 || outf !== 1'b0) begin
      errors++; $display("FAIL b2b_outf got pulses=%0d outf=%b required pulses=%0d outf=0", outf_pulses - p0, outf, 1);
    end
    checks++;
    if (!got_rsp || rsp_data !== 32'hA5A5_0001 || rsp_cyc !== 19) begin
      errors++; $display("FAIL b2b_read got rdata=%h cyc=%0d required a5a50001 cyc=19", rsp_data, rsp_cyc);
    end
  endtask

  task automatic test_cmd_reset();
    int nz;
    do_cmd(2'd2, 4'd0, 32'h1234_5678, 0);
    do_cmd(2'd2, 4'd10, 32'hCAFE_F00D, 0);
    checks++;
    if (tgt_out[0] !== 32'h1234_5678 || tgt_out[10] !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL pre_reset_writes got out0=%h outa=%h required 12345678 cafef00d", tgt_out[0], tgt_out[10]);
    end
    do_cmd(2'd1, 4'd0, 32'd0, 0);
    for (int i = 0; i < 16; i++) ref_out[i] = 32'd0;
    checks++;
    if (ld_byte.size() != 1 || ld_byte[0] !== 8'h10 || !got_rsp || rsp_cyc !== 3) begin
      errors++; $display("FAIL reset_cmd got loads=%0d cyc=%0d required one byte 10 and rsp cycle 3", ld_byte.size(), rsp_cyc);
    end
    nz = 0;
    for (int i = 0; i < 16; i++) if (tgt_out[i] !== 32'd0) nz++;
    checks++;
    if (nz != 0) begin
      errors++; $display("FAIL reset_target got %0d nonzero outputs required 0", nz);
    end
  endtask

  task automatic test_timeout_invalid();
    mute = 1'b1;
    do_cmd(2'd3, 4'd5, 32'd0, 0);
    mute = 1'b0;
    checks++;
    if (!got_rsp || rsp_e !== 1'b1 || rsp_data !== 32'd0 || rsp_rdy_low !== 1'b1) begin
      errors++; $display("FAIL timeout_rsp got rsp=%0d err=%b rdata=%h ready_low=%b required err=1 rdata=0 ready_low=1",
                         got_rsp, rsp_e, rsp_data, rsp_rdy_low);
    end
    checks++;
    if (rsp_cyc < TIMEOUT || rsp_cyc > TIMEOUT + 2 + GAP + 2) begin
      errors++; $display("FAIL timeout_latency got cyc=%0d required about %0d", rsp_cyc, 2 + GAP + TIMEOUT);
    end
    do_cmd(2'd0, 4'd7, 32'hFFFF_FFFF, 0);
    checks++;
    if (!got_rsp || rsp_cyc !== 1 || rsp_e !== 1'b1 || rsp_data !== 32'd0 || ld_byte.size() != 0) begin
      errors++; $display("FAIL invalid_op got cyc=%0d err=%b rdata=%h loads=%0d required cyc=1 err=1 rdata=0 loads=0",
                         rsp_cyc, rsp_e, rsp_data, ld_byte.size());
    end
  endtask

  task automatic test_reset_mid();
    int at;
    for (int r = 0; r < 2; r++) begin
      at = (r == 0) ? 6 : $urandom_range(2, 18);
      do_cmd(2'd3, 4'd15, 32'd0, at);
      @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, rsp_err, load, ready} !== 5'b0 || rsp_rdata !== 32'd0 || datain !== 8'd0) begin
        errors++; $display("FAIL mid_reset_outputs at cycle %0d got cr=%b ld=%b rdy=%b di=%h required all 0",
                           at, cmd_ready, load, ready, datain);
      end
      reset = 1'b0;
      for (int i = 0; i < 16; i++) ref_out[i] = 32'd0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
        errors++; $display("FAIL mid_reset_release got cmd_ready=%b required 1", cmd_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [31:0] wd, exp_rd;
    logic [7:0]  eb;
    int          exp_n, exp_rsp, nbad;
    bit          ok;
    for (int n = 0; n < 24; n++) begin
      op = 2'($urandom_range(0, 3)); addr = 4'($urandom); wd = $urandom;
      for (int i = 0; i < 16; i++) tgt_in[i] = $urandom;
      exp_n   = (op == 2'd0) ? 0 : (op == 2'd2) ? 5 : 1;
      exp_rsp = (op == 2'd0) ? 1 : (op == 2'd3) ? (2 + GAP + 16) : (1 + exp_n * (1 + GAP));
      exp_rd  = 32'd0;
      if (op == 2'd3) exp_rd = (addr == 4'd15) ? 32'h2019_2020 : tgt_in[addr];
      do_cmd(op, addr, wd, 0);
      if (op == 2'd1) for (int i = 0; i < 16; i++) ref_out[i] = 32'd0;
      if (op == 2'd2 && addr != 4'd15) ref_out[addr] = wd;
      checks++;
      if (!got_rsp || rsp_cyc !== exp_rsp || rsp_e !== 1'(op == 2'd0)) begin
        errors++; $display("FAIL rand_rsp op=%0d addr=%0d got cyc=%0d err=%b required cyc=%0d err=%b",
                           op, addr, rsp_cyc, rsp_e, exp_rsp, op == 2'd0);
      end
      ok = (ld_byte.size() == exp_n);
      for (int k = 0; k < exp_n && ok; k++) begin
        eb = (k == 0) ? {2'b00, op, addr} : 8'(wd >> (8 * (4 - k)));
        if (ld_byte[k] !== eb || ld_cyc[k] !== 1 + k * (1 + GAP)) ok = 0;
      end
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rand_bytes op=%0d addr=%0d got %0d loads required %0d", op, addr, ld_byte.size(), exp_n);
      end
      if (op != 2'd3 || addr < 4'd8 || addr == 4'd15) begin
        checks++;
        if (rsp_data !== exp_rd) begin
          errors++; $display("FAIL rand_rdata op=%0d addr=%0d got %h required %h", op, addr, rsp_data, exp_rd);
        end
      end
      nbad = 0;
      for (int i = 0; i < 15; i++) if (tgt_out[i] !== ref_out[i]) nbad++;
      checks++;
      if (nbad != 0) begin
        errors++; $display("FAIL rand_target op=%0d addr=%0d got %0d registers differing required 0", op, addr, nbad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_hwid();
    test_back_to_back();
    test_cmd_reset();
    test_timeout_invalid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ioports_host.md
# ioports_host

Host-side initiator for the 32-bit general-purpose I/O port byte protocol. Takes word-level RESET, WRITE and READ commands from an internal master and serialises each into the byte/strobe sequence the I/O port block consumes. For reads, it runs the ready/enout handshake to collect four bytes and returns one 32-bit response. It sits between the command source (UART/USB bridge or test sequencer) and the I/O port block.

## Interface
- GAP, 1: idle cycles (load low) inserted after every transmitted byte; must be ≥1
- TIMEOUT, 255: maximum cycles to wait for an enout edge before aborting a read
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready
- cmd_op  in  2  1=RESET, 2=WRITE, 3=READ, 0=invalid
- cmd_addr  in  4  port address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse when a command completes
- rsp_rdata  out  32  read data; 0 for non-read or error
- rsp_err  out  1  timeout or invalid op; valid with rsp_valid
- load  out  1  byte strobe to target, one cycle per byte
- datain  out  8  byte to target
- ready  out  1  host ready to consume one read byte
- enout  in  1  target byte-valid
- dataout  in  8  byte from target, valid while enout high

## Operation
- Command byte = {1'b0, op[2:0], addr[3:0]}; op codes RESET=3'b001, WRITE=3'b010, READ=3'b011.
- States: IDLE, SEND, GAP, RD_REQ, RD_REL, DONE.
- IDLE: cmd_ready=1. On accept, latch op, addr and wdata, and clear the byte index.
  - Valid op → SEND.
  - op=0 → DONE with rsp_err=1; nothing is transmitted.
- SEND: load=1 for one cycle, datain = current byte, then → GAP.
  - Byte sequence: RESET = cmd byte only. READ = cmd byte only. WRITE = cmd byte, then wdata[31:24], [23:16], [15:8], [7:0].
- GAP: load=0 and datain holds its value for GAP cycles. Then:
  - more bytes remain → SEND;
  - READ → RD_REQ;
  - otherwise → DONE.
  - The gap is what covers the target's extra delay cycle after writes to address 15.
- RD_REQ: ready=1. When enout=1 is sampled, shift in: rdata = {rdata[23:0], dataout}; drop ready; → RD_REL.
- RD_REL: ready=0. When enout=0 is sampled:
  - fewer than 4 bytes received → RD_REQ;
  - 4 bytes received → DONE.
- Timeout: the wait counter resets on entry to RD_REQ and RD_REL. If it reaches TIMEOUT, deassert ready and → DONE with rsp_err=1, rsp_rdata=0.
- DONE: rsp_valid=1 for one cycle with rdata and err, then → IDLE. There is no backpressure on the response.
- Address handling: READ of addresses 8–14 is transmitted unchanged; the returned data is unspecified and no error is flagged. Address 15 reads the hardware ID 32'h2019_2020.

## Timing
- All outputs are registered.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, load=0, datain=0, ready=0. cmd_ready rises the first cycle after reset deasserts.
- Cycle numbering: the accept edge is at the end of cycle 0.
- With GAP=1 against a zero-wait target:
  - RESET: load in cycle 1; rsp_valid in cycle 3.
  - WRITE: load in cycles 1, 3, 5, 7, 9; rsp_valid in cycle 11.
  - READ: load in cycle 1; ready high in cycles 3–4, 7–8, 11–12, 15–16; rsp_valid in cycle 19.
- Back-to-back commands: cmd_ready returns in the cycle after rsp_valid.
- Reset asserted mid-command: return to IDLE with all outputs at reset values in the next cycle. Target recovery relies on the shared system reset.

## Structure
- Shared package ioports_pkg holds:
  - op codes CMD_RESET, CMD_WRITE, CMD_READ (3-bit);
  - HWID_ADDR = 4'd15;
  - ATLYS_HWID = 32'h2019_2020.
- Single module, no sub-modules: the byte counter, shift register and timeout counter are inline.

## Test plan
- WRITE addr 3, data 32'hDEADBEEF, target in loop → datain sequence 8'h23, DE, AD, BE, EF; target out3=32'hDEADBEEF; rsp_valid in cycle 11, rsp_err=0.
- READ addr 15 → datain 8'h3F; rsp_rdata=32'h2019_2020 in cycle 19.
- WRITE addr 15 of 32'h1, immediately followed by READ addr 0 with in0=32'hA5A5_0001 → outf pulses and returns to 0; read returns 32'hA5A5_0001.
- RESET after writes to out0 and outa → datain 8'h10; all outputs of the target read 0; rsp_valid in cycle 3.
- READ with enout held low → rsp_valid with rsp_err=1 and rsp_rdata=0 after TIMEOUT cycles; ready low at completion. Also: op=0 → rsp_err=1 in cycle 1 and load never asserts.
- Reset asserted in cycle 6 of a READ → load=0 and ready=0 next cycle; cmd_ready=1 after release.
